// File: rtl/skinny_sbox8_dom1_array_seq.sv
// First-order DOM-indep masked SKINNY-128 8-bit S-box array with its own 24-phase sequencer.
// Each S-box evaluates four dependent layers of the registered two-share (x nor y) xor z gadget.
module skinny_sbox8_dom1_array_seq #(
    parameter int NSB = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*NSB-1:0] si0,
    input  logic [8*NSB-1:0] si1,
    input  logic [8*NSB-1:0] r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*NSB-1:0] bo0,
    output logic [8*NSB-1:0] bo1
);
    localparam int W = 8 * NSB;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [4:0]   ph, ph_nxt;
    logic         accept;
    logic [23:0]  cyc;
    logic [W-1:0] si0_q, si1_q, r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ph    <= 5'd0;
            si0_q <= '0;
            si1_q <= '0;
            r_q   <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
            if (accept) begin
                si0_q <= si0;
                si1_q <= si1;
                r_q   <= r;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                    ph_nxt    = 5'd0;
                end
            end
            BUSY: begin
                if (ph == 5'd23) begin
                    state_nxt = DONE;
                    ph_nxt    = 5'd0;
                end else begin
                    ph_nxt = ph + 5'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cyc = (state == BUSY) ? (24'd1 << ph) : 24'd0;

    for (genvar k = 0; k < NSB; k++) begin : g_sb
        logic [7:0] b0, b1, rk, a0, a1;
        logic [7:0] x0, x1, y0, y1, z0, z1;

        assign b0 = si0_q[8*k +: 8];
        assign b1 = si1_q[8*k +: 8];
        assign rk = r_q[8*k +: 8];

        // Operand wiring for a7..a0; later layers read earlier f registers.
        assign x0 = {a0[4], a0[3], a0[2], a0[1], a0[0], b0[2], b0[3], b0[7]};
        assign x1 = {a1[4], a1[3], a1[2], a1[1], a1[0], b1[2], b1[3], b1[7]};
        assign y0 = {a0[5], a0[0], a0[3], b0[3], a0[1], b0[1], b0[2], b0[6]};
        assign y1 = {a1[5], a1[0], a1[3], b1[3], a1[1], b1[1], b1[2], b1[6]};
        assign z0 = {b0[2], b0[3], b0[7], b0[1], b0[5], b0[6], b0[0], b0[4]};
        assign z1 = {b1[2], b1[3], b1[7], b1[1], b1[5], b1[6], b1[0], b1[4]};

        for (genvar j = 0; j < 8; j++) begin : g_fn
            localparam int S = (j < 3) ? 0 : (j < 5) ? 1 : (j < 7) ? 2 : 3;

            logic [5:0] c;
            logic g0, g1, t0, t1, f0, f1;
            logic p0_x1, p0_y1, p0_z1, p1_x0, p1_y0, p1_z0;
            logic p2_x1, p2_y0, p2_r, p3_x0, p3_y1, p3_r;
            logic p4_t0, p4_g0, p5_t1, p5_g1;

            assign c = cyc[6*S +: 6];

            // Operands are zeroed outside their phase so no cone combines both shares.
            assign p0_x1 = x1[j] & c[0];
            assign p0_y1 = y1[j] & c[0];
            assign p0_z1 = z1[j] & c[0];
            assign p1_x0 = x0[j] & c[1];
            assign p1_y0 = y0[j] & c[1];
            assign p1_z0 = z0[j] & c[1];
            assign p2_x1 = x1[j] & c[2];
            assign p2_y0 = y0[j] & c[2];
            assign p2_r  = rk[j] & c[2];
            assign p3_x0 = x0[j] & c[3];
            assign p3_y1 = y1[j] & c[3];
            assign p3_r  = rk[j] & c[3];
            assign p4_t0 = t0 & c[4];
            assign p4_g0 = g0 & c[4];
            assign p5_t1 = t1 & c[5];
            assign p5_g1 = g1 & c[5];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    g0 <= 1'b0;
                    g1 <= 1'b0;
                    t0 <= 1'b0;
                    t1 <= 1'b0;
                    f0 <= 1'b0;
                    f1 <= 1'b0;
                end else begin
                    if (c[0]) g1 <= (~p0_x1 & ~p0_y1) ^ p0_z1;
                    if (c[1]) g0 <= (p1_x0 & p1_y0) ^ p1_z0;
                    if (c[2]) t1 <= (~p2_x1 & p2_y0) ^ p2_r;
                    if (c[3]) t0 <= (p3_x0 & ~p3_y1) ^ p3_r;
                    if (c[4]) f0 <= p4_t0 ^ p4_g0;
                    if (c[5]) f1 <= p5_t1 ^ p5_g1;
                end
            end

            assign a0[j] = f0;
            assign a1[j] = f1;
        end

        assign bo0[8*k +: 8] = {a0[3], a0[0], a0[1], a0[6], a0[4], a0[2], a0[5], a0[7]};
        assign bo1[8*k +: 8] = {a1[3], a1[0], a1[1], a1[6], a1[4], a1[2], a1[5], a1[7]};
    end
endmodule

// File: tb/tb_skinny_sbox8_dom1_array_seq.sv
// Bench for the masked SKINNY S-box array: one single-S-box and one four-S-box instance,
// both checked against an unmasked bit-level S8 reference.
module tb_skinny_sbox8_dom1_array_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv1, ir1, ov1, or1;
    logic [7:0]  s0_1, s1_1, r1, bo0_1, bo1_1;
    logic        iv4, ir4, ov4, or4;
    logic [31:0] s0_4, s1_4, r4, bo0_4, bo1_4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    skinny_sbox8_dom1_array_seq #(.NSB(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .si0(s0_1), .si1(s1_1), .r(r1), .out_valid(ov1), .out_ready(or1),
        .bo0(bo0_1), .bo1(bo1_1)
    );

    skinny_sbox8_dom1_array_seq #(.NSB(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .si0(s0_4), .si1(s1_4), .r(r4), .out_valid(ov4), .out_ready(or4),
        .bo0(bo0_4), .bo1(bo1_4)
    );

    // Unmasked SKINNY-128 S8: four NOR/XOR layers followed by the output bit map.
    function automatic logic [7:0] s8(input logic [7:0] b);
        logic [7:0] a;
        a[0] = ~(b[7] | b[6]) ^ b[4];
        a[1] = ~(b[3] | b[2]) ^ b[0];
        a[2] = ~(b[2] | b[1]) ^ b[6];
        a[3] = ~(a[0] | a[1]) ^ b[5];
        a[4] = ~(a[1] | b[3]) ^ b[1];
        a[5] = ~(a[2] | a[3]) ^ b[7];
        a[6] = ~(a[3] | a[0]) ^ b[3];
        a[7] = ~(a[4] | a[5]) ^ b[2];
        return {a[3], a[0], a[1], a[6], a[4], a[2], a[5], a[7]};
    endfunction

    function automatic logic [31:0] s8w(input logic [31:0] v);
        return {s8(v[31:24]), s8(v[23:16]), s8(v[15:8]), s8(v[7:0])};
    endfunction

    function automatic logic get_ir(input logic w);
        return w ? ir4 : ir1;
    endfunction

    function automatic logic get_ov(input logic w);
        return w ? ov4 : ov1;
    endfunction

    function automatic logic [31:0] get_x(input logic w);
        return w ? (bo0_4 ^ bo1_4) : {24'd0, bo0_1 ^ bo1_1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        s0_1 = a[7:0];
        s1_1 = b[7:0];
        r1   = c[7:0];
        s0_4 = a;
        s1_4 = b;
        r4   = c;
    endtask

    // Accept one operand set, scramble the input buses while busy, and return the number
    // of edges after the accept edge until out_valid is seen (capped at 100).
    task automatic launch(input logic w, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, output int lat);
        drive(a, b, c);
        if (w) iv4 = 1'b1;
        else   iv1 = 1'b1;
        chk("accept_in_ready", get_ir(w), 1);
        @(negedge clk);
        iv1 = 1'b0;
        iv4 = 1'b0;
        lat = 0;
        while (!get_ov(w) && lat < 100) begin
            drive($urandom, $urandom, $urandom);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input logic w);
        if (w) or4 = 1'b1;
        else   or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        or4 = 1'b0;
        chk("xfer_in_ready", get_ir(w), 1);
        chk("xfer_out_valid", get_ov(w), 0);
    endtask

    initial begin
        int          lat;
        int          distinct;
        int          stale;
        logic [31:0] a, v, exp4;
        logic [7:0]  o0, o1;
        bit [255:0]  seen;

        rst = 1'b1;
        iv1 = 1'b0; or1 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
        drive(0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready1", ir1, 1);
        chk("rst_out_valid1", ov1, 0);
        chk("rst_bo0_1", bo0_1, 0);
        chk("rst_bo1_1", bo1_1, 0);
        chk("rst_in_ready4", ir4, 1);
        chk("rst_out_valid4", ov4, 0);
        chk("rst_bo0_4", bo0_4, 0);
        chk("rst_bo1_4", bo1_4, 0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero shares and mask; accept edge counts as the first of 25.
        launch(0, 0, 0, 0, lat);
        chk("latency_zero", lat, 24);
        chk("s8_00", get_x(0), 32'h65);
        take(0);

        seen = '0;
        distinct = 0;
        for (int i = 0; i < 100; i++) begin
            launch(0, 32'hA5, 32'h5A, $urandom, lat);
            chk("latency_ff", lat, 24);
            chk("s8_ff", get_x(0), 32'hFF);
            if (!seen[bo0_1]) begin
                seen[bo0_1] = 1'b1;
                distinct++;
            end
            take(0);
        end
        chk("share_spread", distinct > 1, 1);

        a = $urandom;
        launch(0, a, a ^ 32'h01, $urandom, lat);
        chk("s8_01", get_x(0), 32'h4C);
        take(0);

        // Consumer stalls in DONE; in_valid pulses must be ignored, including in the transfer cycle.
        a = $urandom;
        launch(0, a, a ^ 32'h3C, $urandom, lat);
        chk("s8_3c", get_x(0), {24'd0, s8(8'h3C)});
        o0 = bo0_1;
        o1 = bo1_1;
        for (int i = 0; i < 10; i++) begin
            iv1 = i[0];
            @(negedge clk);
            chk("hold_out_valid", ov1, 1);
            chk("hold_bo0", bo0_1, o0);
            chk("hold_bo1", bo1_1, o1);
            chk("hold_in_ready", ir1, 0);
        end
        iv1 = 1'b1;
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        chk("release_in_ready", ir1, 1);
        chk("release_out_valid", ov1, 0);
        iv1 = 1'b0;
        @(negedge clk);

        // Reset while the sequencer sits at ph=12.
        a = $urandom;
        drive(a, a ^ 32'h77, $urandom);
        iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        repeat (12) begin
            drive($urandom, $urandom, $urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", ir1, 1);
        chk("midrst_out_valid", ov1, 0);
        chk("midrst_bo0", bo0_1, 0);
        chk("midrst_bo1", bo1_1, 0);
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        repeat (30) begin
            @(negedge clk);
            if (ov1) stale++;
        end
        chk("no_stale_valid", stale, 0);
        a = $urandom;
        launch(0, a, a ^ 32'h77, $urandom, lat);
        chk("latency_after_rst", lat, 24);
        chk("s8_77_after_rst", get_x(0), {24'd0, s8(8'h77)});
        take(0);

        // Four lanes, inputs scrambled during BUSY.
        a = $urandom;
        launch(1, a, a ^ 32'h0001FF10, $urandom, lat);
        exp4 = {8'h65, 8'h4C, 8'hFF, s8(8'h10)};
        chk("latency_nsb4", lat, 24);
        chk("nsb4_lanes", get_x(1), exp4);
        take(1);

        for (int v8 = 0; v8 < 256; v8 += 4) begin
            v = {8'(v8 + 3), 8'(v8 + 2), 8'(v8 + 1), 8'(v8)};
            a = $urandom;
            launch(1, a, a ^ v, $urandom, lat);
            chk("sweep_latency", lat, 24);
            chk("sweep_s8", get_x(1), s8w(v));
            take(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
